// File: rtl/sync_fifo_prog_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog_if
//
// Purpose: bundles every non-clock signal of sync_fifo_prog so the producer,
// the consumer and the checkers can all attach to one object.
//
// Handshake semantics (the only flow-control contract of this FIFO):
//   * winc is a write request. It is accepted on a rising wclk edge only
//     when wfull is low in the cycle before that edge. A rejected request is
//     dropped (not held). It also sets the sticky overflow flag.
//   * rinc is a read request. It is accepted on a rising wclk edge only
//     when rempty is low in the cycle before that edge. A rejected request
//     is dropped. It also sets the sticky underflow flag.
//   * wfull/rempty act as the ready/valid of the two sides. They are
//     decoded from registered state only, so a request never
//     combinationally depends on its own acceptance.
//
// Signals:
//   winc, wdata            write request and data           (master -> fifo)
//   rinc                   read request                      (master -> fifo)
//   rdata                  read data                         (fifo -> master)
//   wfull, rempty          occupancy == DEPTH / == 0         (fifo -> master)
//   almost_full            count >= af_thresh (0 disables)   (fifo -> master)
//   almost_empty           count <= ae_thresh                (fifo -> master)
//   count                  exact occupancy 0..DEPTH          (fifo -> master)
//   af_thresh, ae_thresh   quasi-static thresholds           (master -> fifo)
//   overflow, underflow    sticky error flags                (fifo -> master)
//   clr_err                clears both error flags           (master -> fifo)
// ---------------------------------------------------------------------------
interface sync_fifo_prog_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 9
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             almost_full;
    logic             almost_empty;
    logic [ASIZE:0]   count;
    logic [ASIZE:0]   af_thresh;
    logic [ASIZE:0]   ae_thresh;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    // Producer/consumer side.
    modport master (
        output winc, wdata, rinc, af_thresh, ae_thresh, clr_err,
        input  rdata, wfull, rempty, almost_full, almost_empty, count,
               overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  winc, wdata, rinc, af_thresh, ae_thresh, clr_err,
        output rdata, wfull, rempty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
//
// Purpose: single-clock FIFO with exact occupancy count, programmable
// almost-full / almost-empty thresholds, sticky overflow / underflow flags
// and a selectable read mode (registered read, or first-word-fall-through).
//
// Parameters:
//   DSIZE  data width in bits
//   ASIZE  address width, DEPTH = 2**ASIZE entries
//   FWFT   0: rdata is registered on an accepted read
//          1: head entry is shown on rdata without a read (0 when empty)
//
// Ports:
//   wclk    clock, every register updates on its rising edge
//   wrst_n  asynchronous active-low reset
//   bus     sync_fifo_prog_if.slave, carries all data/flag/threshold signals
// ---------------------------------------------------------------------------
module sync_fifo_prog #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 9,
    parameter int FWFT  = 0
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    sync_fifo_prog_if.slave       bus
);

    localparam int             DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] ZERO_C  = '0;

    // Storage is not reset. After a reset the pointers and count make any
    // stale word unreachable.
    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] rptr;
    logic [ASIZE:0]   count_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             wfull_c;
    logic             rempty_c;
    logic             wacc;
    logic             racc;
    logic [ASIZE:0]   count_nxt;

    // -----------------------------------------------------------------------
    // Flag decode, purely from the count register and the thresholds.
    // Full/empty come from the count, never from pointer comparison, so the
    // pointers can wrap freely without an extra wrap bit.
    // -----------------------------------------------------------------------
    assign wfull_c  = (count_q == DEPTH_C);
    assign rempty_c = (count_q == ZERO_C);

    // A zero almost-full threshold would make the flag permanently high,
    // so zero is treated as "disabled". Thresholds above DEPTH are never
    // reached by the count, so they disable the flag without special logic.
    assign bus.almost_full  = (bus.af_thresh != ZERO_C) && (count_q >= bus.af_thresh);
    assign bus.almost_empty = (count_q <= bus.ae_thresh);

    assign bus.wfull     = wfull_c;
    assign bus.rempty    = rempty_c;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // -----------------------------------------------------------------------
    // Accept decisions. Each side looks only at its own flag from the state
    // before the edge. A read cannot make room for a write in the same cycle
    // when full, and a write cannot feed a read in the same cycle when empty.
    // -----------------------------------------------------------------------
    assign wacc = bus.winc & ~wfull_c;
    assign racc = bus.rinc & ~rempty_c;

    // Accept rules guarantee the result stays inside 0..DEPTH.
    always_comb begin
        count_nxt = count_q;
        if (wacc && !racc) begin
            count_nxt = count_q + 1'b1;
        end else if (racc && !wacc) begin
            count_nxt = count_q - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Pointers, count and sticky error flags.
    // -----------------------------------------------------------------------
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (wacc) begin
                wptr <= wptr + 1'b1;
            end
            if (racc) begin
                rptr <= rptr + 1'b1;
            end
            count_q <= count_nxt;
        end
    end

    // A new error in the same cycle as clr_err wins. Otherwise the error
    // would be lost silently.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.winc && wfull_c) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end

            if (bus.rinc && rempty_c) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Memory write port.
    // -----------------------------------------------------------------------
    always_ff @(posedge wclk) begin
        if (wacc) begin
            mem[wptr] <= bus.wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read data path.
    // -----------------------------------------------------------------------
    generate
        if (FWFT == 0) begin : g_std_read
            logic [DSIZE-1:0] rdata_q;

            // Uses the pre-increment rptr, so the word leaving the FIFO on
            // this edge is the one captured.
            always_ff @(posedge wclk or negedge wrst_n) begin
                if (!wrst_n) begin
                    rdata_q <= '0;
                end else if (racc) begin
                    rdata_q <= mem[rptr];
                end
            end

            assign bus.rdata = rdata_q;
        end else begin : g_fwft_read
            // The head word is shown directly. A read just advances rptr
            // past it. The output is forced to zero while empty, so stale
            // memory never leaks out.
            assign bus.rdata = rempty_c ? '0 : mem[rptr];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_prog
//
// Two FIFOs, one per read mode, receive identical stimulus. The driver
// keeps a reference occupancy/error model and pushes every accepted write
// into exp_q. A separate monitor pops exp_q whenever the standard-mode FIFO
// has completed a read. On every cycle it also compares the FWFT FIFO's
// rdata with the oldest unread word.
// ---------------------------------------------------------------------------
module tb_sync_fifo_prog;

    localparam int DSIZE = 8;
    localparam int ASIZE = 9;
    localparam int DEPTH = 1 << ASIZE;
    localparam int AF    = 384;
    localparam int AE    = 64;

    logic wclk;
    logic wrst_n;

    sync_fifo_prog_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus0 ();
    sync_fifo_prog_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus1 ();

    sync_fifo_prog #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(0)) dut_std (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus0)
    );

    sync_fifo_prog #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(1)) dut_fwft (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus1)
    );

    // ---------------- clock / reset ----------------
    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [DSIZE-1:0] exp_q[$];
    int               checks   = 0;
    int               failures = 0;
    int               mdl_cnt  = 0;
    logic             mdl_ovf  = 1'b0;
    logic             mdl_unf  = 1'b0;
    logic             rd_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    // Standard-mode read completed on the last edge: the DUT now presents it.
    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rd_seen <= 1'b0;
        end else begin
            rd_seen <= bus0.rinc && !bus0.rempty;
        end
    end

    always @(negedge wclk) begin
        logic [DSIZE-1:0] exp_d;
        if (wrst_n) begin
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got %0h expected no read at %0t", bus0.rdata, $time);
                end else begin
                    exp_d = exp_q.pop_front();
                    chk("rdata_std", 32'(bus0.rdata), 32'(exp_d));
                end
            end
            if (exp_q.size() > 0) begin
                chk("rdata_fwft", 32'(bus1.rdata), 32'(exp_q[0]));
            end else begin
                chk("rdata_fwft_empty", 32'(bus1.rdata), 32'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic w, input logic [DSIZE-1:0] d, input logic r, input logic c);
        bus0.winc = w; bus0.wdata = d; bus0.rinc = r; bus0.clr_err = c;
        bus1.winc = w; bus1.wdata = d; bus1.rinc = r; bus1.clr_err = c;
    endtask

    task automatic check_flags(input string tag);
        logic exp_af;
        logic exp_ae;
        exp_af = (AF != 0) && (mdl_cnt >= AF);
        exp_ae = (mdl_cnt <= AE);
        chk({tag, "_count"},     32'(bus0.count),        32'(mdl_cnt));
        chk({tag, "_count_f"},   32'(bus1.count),        32'(mdl_cnt));
        chk({tag, "_wfull"},     32'(bus0.wfull),        32'(mdl_cnt == DEPTH));
        chk({tag, "_rempty"},    32'(bus0.rempty),       32'(mdl_cnt == 0));
        chk({tag, "_afull"},     32'(bus0.almost_full),  32'(exp_af));
        chk({tag, "_aempty"},    32'(bus0.almost_empty), 32'(exp_ae));
        chk({tag, "_overflow"},  32'(bus0.overflow),     32'(mdl_ovf));
        chk({tag, "_underflow"}, 32'(bus0.underflow),    32'(mdl_unf));
    endtask

    // One clock cycle: drive at the negedge, let the edge happen, update the
    // model, check flags at the following negedge.
    task automatic cycle(input string tag, input logic w, input logic [DSIZE-1:0] d,
                         input logic r, input logic c);
        logic wacc;
        logic racc;
        drive(w, d, r, c);
        wacc = w && (mdl_cnt != DEPTH);
        racc = r && (mdl_cnt != 0);
        @(posedge wclk);
        if (w && mdl_cnt == DEPTH) mdl_ovf = 1'b1;
        else if (c)                mdl_ovf = 1'b0;
        if (r && mdl_cnt == 0)     mdl_unf = 1'b1;
        else if (c)                mdl_unf = 1'b0;
        if (wacc) exp_q.push_back(d);
        mdl_cnt = mdl_cnt + int'(wacc) - int'(racc);
        @(negedge wclk);
        check_flags(tag);
    endtask

    task automatic idle_check_reset(input string tag);
        chk({tag, "_count"},     32'(bus0.count),        32'h0);
        chk({tag, "_rempty"},    32'(bus0.rempty),       32'h1);
        chk({tag, "_wfull"},     32'(bus0.wfull),        32'h0);
        chk({tag, "_aempty"},    32'(bus0.almost_empty), 32'h1);
        chk({tag, "_afull"},     32'(bus0.almost_full),  32'h0);
        chk({tag, "_overflow"},  32'(bus0.overflow),     32'h0);
        chk({tag, "_underflow"}, 32'(bus0.underflow),    32'h0);
        chk({tag, "_rdata"},     32'(bus0.rdata),        32'h0);
        chk({tag, "_rdata_f"},   32'(bus1.rdata),        32'h0);
        chk({tag, "_count_f"},   32'(bus1.count),        32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wrst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        bus0.af_thresh = 10'(AF); bus0.ae_thresh = 10'(AE);
        bus1.af_thresh = 10'(AF); bus1.ae_thresh = 10'(AE);

        repeat (2) @(negedge wclk);
        idle_check_reset("reset");
        wrst_n = 1'b1;
        @(negedge wclk);

        // Single word round trip.
        cycle("wr_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
        cycle("rd_a5", 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full, also sweeps the almost-full/almost-empty edges.
        for (int i = 0; i < DEPTH; i++) begin
            cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        end
        cycle("ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
        cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Sustained simultaneous traffic at count = DEPTH-1 across wraps.
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle("pre", 1'b1, 8'((i * 7) + 3), 1'b0, 1'b0);
        end
        for (int k = 0; k < 2000; k++) begin
            cycle("stream", 1'b1, 8'(k) ^ 8'h5A, 1'b1, 1'b0);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle("post", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Empty: write accepted, read rejected; then clear with a good read.
        cycle("unf", 1'b1, 8'h5A, 1'b1, 1'b0);
        cycle("unf_clr", 1'b0, 8'h00, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 200; i++) begin
            cycle("burst", 1'b1, 8'(i + 100), 1'b0, 1'b0);
        end
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        #2;
        wrst_n = 1'b0;
        #1;
        idle_check_reset("async_rst");
        exp_q.delete();
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(negedge wclk);
        cycle("post_rst_w0", 1'b1, 8'h3C, 1'b0, 1'b0);
        cycle("post_rst_w1", 1'b1, 8'h4D, 1'b0, 1'b0);
        cycle("post_rst_r0", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("post_rst_r1", 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge wclk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, an exact occupancy count, sticky overflow/underflow error flags and a selectable read mode: standard or first-word-fall-through (FWFT). It is the same-clock companion to the team's dual-clock FIFO. Use it wherever producer and consumer share wclk and flow control needs finer occupancy information than full/empty.

## Interface
Parameters:
- DSIZE, 8, data width in bits
- ASIZE, 9, address width; DEPTH = 2**ASIZE entries
- FWFT, 0, read mode: 0 = registered read data, 1 = head entry visible on rdata without a read

Ports:
- wclk  in  1  clock; every register updates on its rising edge
- wrst_n  in  1  reset, asynchronous, active-low
- winc  in  1  write request
- wdata  in  DSIZE  write data
- rinc  in  1  read request
- rdata  out  DSIZE  read data
- wfull  out  1  count == DEPTH
- rempty  out  1  count == 0
- almost_full  out  1  count >= af_thresh; forced 0 when af_thresh == 0
- almost_empty  out  1  count <= ae_thresh
- count  out  ASIZE+1  current occupancy, 0..DEPTH
- af_thresh  in  ASIZE+1  almost-full threshold, quasi-static
- ae_thresh  in  ASIZE+1  almost-empty threshold, quasi-static
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty
- clr_err  in  1  clears overflow and underflow

## Operation
Storage and pointers:
- Memory is DEPTH x DSIZE. Memory contents are not reset.
- Binary pointers wptr and rptr are ASIZE bits wide and wrap naturally from DEPTH-1 to 0.

Accept rules:
- wacc = winc & ~wfull.
- racc = rinc & ~rempty.
- Both flags are evaluated from the register state before the edge. When full, a write is rejected even if a read is accepted in the same cycle. When empty, a read is rejected even if a write is accepted in the same cycle.

Pointer and count update on each edge:
- On wacc: mem[wptr] <= wdata and wptr += 1.
- On racc: rptr += 1.
- count <= count + wacc - racc, computed in ASIZE+1 bits. Wrap is impossible because of the accept rules.

Flags:
- wfull, rempty, almost_full and almost_empty are decoded combinationally from the count register and the threshold inputs.
- No extra pipeline stage on the flags.

Read data, FWFT=0:
- On racc, rdata <= mem[rptr]. This is the pre-increment rptr.
- rdata otherwise holds its value.

Read data, FWFT=1:
- rdata = mem[rptr] combinationally while rempty = 0.
- rdata = 0 while rempty = 1.
- racc consumes the displayed word.

Error flags:
- overflow is set by winc & wfull.
- underflow is set by rinc & rempty.
- A set has priority over clr_err in the same cycle. With clr_err and no set, the flag clears next edge.
- Errors never change pointers, count or memory.

Thresholds:
- af_thresh values above DEPTH mean almost_full never asserts.
- ae_thresh >= DEPTH means almost_empty is always 1.

## Timing
Reset state while wrst_n = 0, applied asynchronously:
- wptr = 0, rptr = 0, count = 0
- rempty = 1, wfull = 0, almost_empty = 1
- almost_full = 0, because count = 0 < af_thresh or af_thresh == 0
- overflow = 0, underflow = 0, rdata = 0
- Reset mid-operation discards all contents. Memory may keep stale data, but it is unreachable.

Write-to-read latency:
- A write accepted at edge N gives count/rempty updated after edge N.
- FWFT=1: the word appears on rdata after edge N if the FIFO was empty.
- FWFT=0: the earliest read is accepted at edge N+1, and its data is on rdata after edge N+1.

Steady-state rates:
- Sustained throughput is one write and one read per cycle.
- With simultaneous wacc and racc, count is unchanged.

Wrap-around:
- Pointers wrap with no bubble.
- Full is determined by count, never by pointer comparison.

## Test plan
- Reset, then 1 write of 0xA5 (FWFT=0): count = 1, rempty = 0. A read on the next cycle gives rdata = 0xA5 after the edge, count = 0, rempty = 1.
- Fill with DEPTH writes 0..DEPTH-1 mod 256: wfull = 1 and count = DEPTH after the last edge. One more winc: overflow = 1, count unchanged, no memory write. Then read all words in order and check the data.
- af_thresh = 384, ae_thresh = 64, DEPTH = 512: almost_full rises on the edge where count reaches 384. almost_empty falls when count reaches 65 and rises again on the return to 64.
- With count = 511, drive winc & rinc for 2000 cycles: count stays 511, data ordering is preserved across several pointer wraps, no error flags. With FWFT=1, rdata always equals the oldest unread word.
- Empty FIFO with rinc & winc in the same cycle: write accepted, read rejected, underflow = 1, count = 1. Then clr_err together with rinc & rempty = 0: underflow clears after the edge.
- Assert wrst_n = 0 asynchronously mid-burst at count = 200: all outputs take reset values immediately, without waiting for a wclk edge. After release, the first written word is the first word read.
